wave_result_filter: RTL and testbench

WAVE_RESULT_FILTER -- requirements
Module: wave_result_filter

---
 rtl/wave_result_filter.sv | 136 +++++++++++++
 tb/tb_wave_result_filter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wave_result_filter.sv
// wave_result_filter: collects VOTE_DEPTH waveform measurements per window and
// publishes the mean Vpp, the peak papr and a voted waveform class through a
// valid/ready result register with a sticky overrun flag.
// Optional feature: define WAVE_HYST_EN to require two consecutive windows of
// a new class before the published wave_type changes.
module wave_result_filter #(
   parameter int N               = 8,
   parameter int VOTE_DEPTH      = 8,
   parameter int LOG2_VOTE_DEPTH = 3,
   parameter int MIN_VPP         = 16,
   parameter int SQ_PAPR_MAX     = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         meas_valid,
   input  logic [N-1:0] vpp_in,
   input  logic [7:0]   papr_in,
   input  logic         is_sine_in,
   input  logic         res_ready,
   output logic         res_valid,
   output logic [1:0]   wave_type,
   output logic [N-1:0] vpp_avg,
   output logic [7:0]   papr_max,
   output logic         overrun
);

   localparam int SW = N + LOG2_VOTE_DEPTH;
   localparam int CW = LOG2_VOTE_DEPTH + 1;

   typedef enum logic {S_ACC, S_CALC} state_t;

   state_t          state_q;
   logic [SW-1:0]   sum_q;
   logic [CW-1:0]   votes_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      pmax_q;
   logic            res_valid_q;
   logic [1:0]      wave_type_q;
   logic [N-1:0]    vpp_avg_q;
   logic [7:0]      papr_max_q;
   logic            overrun_q;
`ifdef WAVE_HYST_EN
   logic [1:0]      hist_q;
`endif

   logic [N-1:0]    avg_d;
   logic [1:0]      class_d;
   logic [1:0]      pub_d;

   // Window mean, class vote, and the class actually published this window
   always_comb begin
      avg_d   = sum_q[SW-1 -: N];
      class_d = 2'd3;
      if (avg_d < N'(MIN_VPP))
         class_d = 2'd0;
      else if (votes_q > CW'(VOTE_DEPTH / 2))
         class_d = 2'd1;
      else if (pmax_q <= 8'(SQ_PAPR_MAX))
         class_d = 2'd2;
      pub_d = class_d;
`ifdef WAVE_HYST_EN
      if ((class_d != wave_type_q) && (hist_q != class_d))
         pub_d = wave_type_q;
`endif
   end

   // Accumulate/calculate FSM with registered result and handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_ACC;
         sum_q       <= '0;
         votes_q     <= '0;
         cnt_q       <= '0;
         pmax_q      <= '0;
         res_valid_q <= 1'b0;
         wave_type_q <= '0;
         vpp_avg_q   <= '0;
         papr_max_q  <= '0;
         overrun_q   <= 1'b0;
`ifdef WAVE_HYST_EN
         hist_q      <= '0;
`endif
      end else begin
         case (state_q)
            S_ACC: begin
               if (meas_valid) begin
                  sum_q   <= sum_q + SW'(vpp_in);
                  votes_q <= votes_q + CW'(is_sine_in);
                  cnt_q   <= cnt_q + CW'(1);
                  if (papr_in > pmax_q)
                     pmax_q <= papr_in;
                  if (cnt_q == CW'(VOTE_DEPTH - 1))
                     state_q <= S_CALC;
               end
               if (res_valid_q && res_ready) begin
                  res_valid_q <= 1'b0;
                  overrun_q   <= 1'b0;
               end
            end
            S_CALC: begin
               state_q <= S_ACC;
               // A strobe landing here seeds the next window instead of being lost
               if (meas_valid) begin
                  sum_q   <= SW'(vpp_in);
                  votes_q <= CW'(is_sine_in);
                  cnt_q   <= CW'(1);
                  pmax_q  <= papr_in;
               end else begin
                  sum_q   <= '0;
                  votes_q <= '0;
                  cnt_q   <= '0;
                  pmax_q  <= '0;
               end
               vpp_avg_q   <= avg_d;
               papr_max_q  <= pmax_q;
               wave_type_q <= pub_d;
`ifdef WAVE_HYST_EN
               hist_q      <= class_d;
`endif
               res_valid_q <= 1'b1;
               // Loading over an accepted result keeps overrun as it was
               if (res_valid_q && !res_ready)
                  overrun_q <= 1'b1;
            end
            default: state_q <= S_ACC;
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign wave_type = wave_type_q;
   assign vpp_avg   = vpp_avg_q;
   assign papr_max  = papr_max_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_wave_result_filter.sv
// Directed bench for wave_result_filter (default parameters).
module tb_wave_result_filter;

   logic       clk = 1'b0;
   logic       rst_n, meas_valid, is_sine_in, res_ready;
   logic [7:0] vpp_in, papr_in;
   logic       res_valid, overrun;
   logic [1:0] wave_type;
   logic [7:0] vpp_avg, papr_max;

   int passed = 0;
   int total  = 0;

   logic [1:0] m_pub, m_hist;

   always #5 clk = ~clk;

   wave_result_filter #(
      .N(8), .VOTE_DEPTH(8), .LOG2_VOTE_DEPTH(3), .MIN_VPP(16), .SQ_PAPR_MAX(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .meas_valid(meas_valid), .vpp_in(vpp_in),
      .papr_in(papr_in), .is_sine_in(is_sine_in), .res_ready(res_ready),
      .res_valid(res_valid), .wave_type(wave_type), .vpp_avg(vpp_avg),
      .papr_max(papr_max), .overrun(overrun)
   );

   typedef struct {
      logic [7:0] va, vb, pa, pb;
      logic [7:0] smask;
      logic [1:0] cls;
      logic [7:0] avg, pmax;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle-cycle inputs carry junk that must not be sampled
   task automatic strobe(input logic [7:0] v, input logic [7:0] p, input logic s);
      meas_valid = 1'b1; vpp_in = v; papr_in = p; is_sine_in = s;
      tick();
      meas_valid = 1'b0; vpp_in = 8'hAA; papr_in = 8'hFF; is_sine_in = 1'b1;
   endtask

   task automatic model_step(input logic [1:0] c, output logic [1:0] pub);
`ifdef WAVE_HYST_EN
      pub = ((c == m_pub) || (c == m_hist)) ? c : m_pub;
`else
      pub = c;
`endif
      m_pub  = pub;
      m_hist = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; meas_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      m_pub = 2'd0; m_hist = 2'd0;
   endtask

   // Called right after the final strobe's edge: result must appear one edge later
   task automatic expect_result(input string tag, input logic [1:0] cls,
                                input logic [7:0] avg, input logic [7:0] pmax);
      logic [1:0] pub;
      check({tag, ".valid_early"}, int'(res_valid), 0);
      tick();
      model_step(cls, pub);
      check({tag, ".valid"}, int'(res_valid), 1);
      check({tag, ".wave_type"}, int'(wave_type), int'(pub));
      check({tag, ".vpp_avg"}, int'(vpp_avg), int'(avg));
      check({tag, ".papr_max"}, int'(papr_max), int'(pmax));
      check({tag, ".overrun"}, int'(overrun), 0);
   endtask

   task automatic window(input logic [7:0] v, input logic [7:0] p, input logic [7:0] smask);
      for (int j = 0; j < 8; j++) strobe(v, p, smask[j]);
   endtask

   initial begin
      logic [1:0] pub;
      vecs[0] = '{8'd100, 8'd100, 8'd8,  8'd8,  8'hFF, 2'd1, 8'd100, 8'd8};
      vecs[1] = '{8'd200, 8'd200, 8'd4,  8'd4,  8'h0F, 2'd2, 8'd200, 8'd4};
      vecs[2] = '{8'd10,  8'd10,  8'd8,  8'd8,  8'hFF, 2'd0, 8'd10,  8'd8};
      vecs[3] = '{8'd255, 8'd0,   8'd20, 8'd20, 8'h00, 2'd3, 8'd127, 8'd20};
      vecs[4] = '{8'd50,  8'd50,  8'd3,  8'd7,  8'h1F, 2'd1, 8'd50,  8'd7};
      vecs[5] = '{8'd16,  8'd16,  8'd6,  8'd6,  8'h00, 2'd2, 8'd16,  8'd6};
      vecs[6] = '{8'd15,  8'd16,  8'd9,  8'd9,  8'hFF, 2'd0, 8'd15,  8'd9};
      vecs[7] = '{8'd40,  8'd40,  8'd7,  8'd7,  8'hF0, 2'd3, 8'd40,  8'd7};

      meas_valid = 1'b0; vpp_in = '0; papr_in = '0; is_sine_in = 1'b0;
      res_ready = 1'b1; rst_n = 1'b0;
      do_reset();
      check("rst.res_valid", int'(res_valid), 0);
      check("rst.wave_type", int'(wave_type), 0);
      check("rst.vpp_avg", int'(vpp_avg), 0);
      check("rst.papr_max", int'(papr_max), 0);
      check("rst.overrun", int'(overrun), 0);

      // Table: one full window per entry, accepted immediately
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++)
            strobe(j[0] ? vecs[i].vb : vecs[i].va, j[0] ? vecs[i].pb : vecs[i].pa,
                   vecs[i].smask[j]);
         expect_result($sformatf("vec%0d", i), vecs[i].cls, vecs[i].avg, vecs[i].pmax);
         tick();
         check($sformatf("vec%0d.drop", i), int'(res_valid), 0);
      end

      // Overrun: two unaccepted windows, then a single-cycle accept
      res_ready = 1'b0;
      window(8'd100, 8'd8, 8'hFF);
      tick();
      model_step(2'd1, pub);
      check("ovr.first_valid", int'(res_valid), 1);
      check("ovr.first_overrun", int'(overrun), 0);
      tick(); tick(); tick();
      check("ovr.hold_valid", int'(res_valid), 1);
      check("ovr.hold_avg", int'(vpp_avg), 100);
      window(8'd200, 8'd4, 8'h00);
      tick();
      model_step(2'd2, pub);
      check("ovr.second_valid", int'(res_valid), 1);
      check("ovr.second_overrun", int'(overrun), 1);
      check("ovr.second_avg", int'(vpp_avg), 200);
      check("ovr.second_type", int'(wave_type), int'(pub));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("ovr.accept_valid", int'(res_valid), 0);
      check("ovr.accept_overrun", int'(overrun), 0);
      res_ready = 1'b1;

      // Strobe during S_CALC seeds the next window
      window(8'd40, 8'd5, 8'h00);
      strobe(8'd160, 8'd3, 1'b1);
      model_step(2'd2, pub);
      check("calc.valid", int'(res_valid), 1);
      check("calc.avg", int'(vpp_avg), 40);
      check("calc.pmax", int'(papr_max), 5);
      for (int j = 0; j < 7; j++) strobe(8'd80, 8'd3, 1'b1);
      expect_result("calc.next", 2'd1, 8'd90, 8'd3);
      tick();

      // Reset mid-window discards the partial window
      for (int j = 0; j < 5; j++) strobe(8'd200, 8'd30, 1'b1);
      do_reset();
      check("rstmid.valid", int'(res_valid), 0);
      for (int j = 0; j < 3; j++) strobe(8'd60, 8'd9, 1'b0);
      tick(); tick();
      check("rstmid.no_result", int'(res_valid), 0);
      for (int j = 0; j < 5; j++) strobe(8'd60, 8'd9, 1'b0);
      expect_result("rstmid.full", 2'd3, 8'd60, 8'd9);
      tick();

`ifdef WAVE_HYST_EN
      do_reset();
      window(8'd100, 8'd8, 8'hFF);
      expect_result("hyst.sine1", 2'd1, 8'd100, 8'd8);
      tick();
      window(8'd100, 8'd8, 8'hFF);
      expect_result("hyst.sine2", 2'd1, 8'd100, 8'd8);
      check("hyst.sine2_type", int'(wave_type), 1);
      tick();
      window(8'd200, 8'd4, 8'h00);
      expect_result("hyst.sq1", 2'd2, 8'd200, 8'd4);
      check("hyst.sq1_type", int'(wave_type), 1);
      tick();
      window(8'd200, 8'd4, 8'h00);
      expect_result("hyst.sq2", 2'd2, 8'd200, 8'd4);
      check("hyst.sq2_type", int'(wave_type), 2);
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
